bg_ram_arbiter: RTL and testbench

BG_RAM_ARBITER -- requirements
Module: bg_ram_arbiter

---
 rtl/bg_ram_arbiter_if.sv | 29 ++
 rtl/bg_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_bg_ram_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bg_ram_arbiter_if.sv
// Bundle of display, query and frame-RAM signals shared by the background RAM arbiter.
// The slave modport faces the arbiter; the master modport faces the surrounding system.
interface bg_ram_arbiter_if;
    logic        pix_en;
    logic        active;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [23:0] disp_rgb;
    logic        disp_valid;
    logic        q_req;
    logic [9:0]  q_x;
    logic [9:0]  q_y;
    logic        q_busy;
    logic        q_ack;
    logic [23:0] q_rgb;
    logic        q_err;
    logic [18:0] ram_addr;
    logic [23:0] ram_data;

    modport slave (
        input  pix_en, active, DrawX, DrawY, q_req, q_x, q_y, ram_data,
        output disp_rgb, disp_valid, q_busy, q_ack, q_rgb, q_err, ram_addr
    );

    modport master (
        output pix_en, active, DrawX, DrawY, q_req, q_x, q_y, ram_data,
        input  disp_rgb, disp_valid, q_busy, q_ack, q_rgb, q_err, ram_addr
    );
endinterface

// File: rtl/bg_ram_arbiter.sv
// Shares one background frame RAM read port between the display pipeline and game-logic
// point queries; display reads always win, queries use the remaining slots.
module bg_ram_arbiter (
    input logic             clk,
    input logic             rst,
    bg_ram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, CHECK, PEND, WAIT1, WAIT2, DONE} qState_t;

    localparam logic SRC_DISP  = 1'b0;
    localparam logic SRC_QUERY = 1'b1;

    qState_t     state_q, state_d;
    logic [9:0]  qX_q, qX_d, qY_q, qY_d;
    logic [18:0] ramAddr_q, ramAddr_d;
    logic        tag1Valid_q, tag1Valid_d, tag1Src_q, tag1Src_d;
    logic        tag2Valid_q, tag2Src_q;
    logic [23:0] dispRgb_q, dispRgb_d;
    logic        dispValid_q, dispValid_d;
    logic [23:0] qRgb_q, qRgb_d;
    logic        qErr_q, qErr_d;

    logic        dispSlot;
    logic        queryIssue;
    logic [18:0] dispAddr;
    logic [18:0] qAddr;

    // y*640 + x built from shifts: y*512 + y*128 + x
    function automatic logic [18:0] pixAddr(input logic [9:0] x, input logic [9:0] y);
        return {y, 9'b0} + {2'b0, y, 7'b0} + {9'b0, x};
    endfunction

    assign dispSlot   = bus.pix_en & bus.active;
    assign dispAddr   = pixAddr(bus.DrawX, bus.DrawY);
    assign qAddr      = pixAddr(qX_q, qY_q);
    assign queryIssue = (state_q == PEND) && !dispSlot;

    always_comb begin
        state_d = state_q;
        qX_d    = qX_q;
        qY_d    = qY_q;
        qRgb_d  = qRgb_q;
        qErr_d  = qErr_q;
        case (state_q)
            IDLE: begin
                if (bus.q_req) begin
                    qX_d    = bus.q_x;
                    qY_d    = bus.q_y;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (qX_q >= 10'd640 || qY_q >= 10'd480) begin
                    qRgb_d  = 24'd0;
                    qErr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!dispSlot) state_d = WAIT1;
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                qRgb_d  = bus.ram_data;
                qErr_d  = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Issue mux plus the tag pipe that tells the capture stage who owns ram_data
    always_comb begin
        ramAddr_d   = ramAddr_q;
        tag1Valid_d = 1'b0;
        tag1Src_d   = SRC_DISP;
        if (dispSlot) begin
            ramAddr_d   = dispAddr;
            tag1Valid_d = 1'b1;
        end else if (queryIssue) begin
            ramAddr_d   = qAddr;
            tag1Valid_d = 1'b1;
            tag1Src_d   = SRC_QUERY;
        end
        dispRgb_d   = dispRgb_q;
        dispValid_d = 1'b0;
        if (tag2Valid_q && tag2Src_q == SRC_DISP) begin
            dispRgb_d   = bus.ram_data;
            dispValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            qX_q        <= 10'd0;
            qY_q        <= 10'd0;
            ramAddr_q   <= 19'd0;
            tag1Valid_q <= 1'b0;
            tag1Src_q   <= SRC_DISP;
            tag2Valid_q <= 1'b0;
            tag2Src_q   <= SRC_DISP;
            dispRgb_q   <= 24'd0;
            dispValid_q <= 1'b0;
            qRgb_q      <= 24'd0;
            qErr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qX_q        <= qX_d;
            qY_q        <= qY_d;
            ramAddr_q   <= ramAddr_d;
            tag1Valid_q <= tag1Valid_d;
            tag1Src_q   <= tag1Src_d;
            tag2Valid_q <= tag1Valid_q;
            tag2Src_q   <= tag1Src_q;
            dispRgb_q   <= dispRgb_d;
            dispValid_q <= dispValid_d;
            qRgb_q      <= qRgb_d;
            qErr_q      <= qErr_d;
        end
    end

    assign bus.ram_addr   = ramAddr_q;
    assign bus.disp_rgb   = dispRgb_q;
    assign bus.disp_valid = dispValid_q;
    assign bus.q_busy     = (state_q != IDLE);
    assign bus.q_ack      = (state_q == DONE);
    assign bus.q_rgb      = qRgb_q;
    assign bus.q_err      = qErr_q;

endmodule

// File: tb/tb_bg_ram_arbiter.sv
// Bench for bg_ram_arbiter: directed scenarios then random traffic, compared every cycle
// against a timing-rule model of display and query reads over a synchronous frame RAM.
module tb_bg_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #10 clk = ~clk;

    bg_ram_arbiter_if bus ();

    bg_ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [23:0] ramColor(input logic [18:0] a);
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, 5'd0, a[18:16]};
    endfunction

    // Synchronous frame RAM: data for an address appears one edge after it is presented
    always @(posedge clk) bus.ram_data <= ramColor(bus.ram_addr);

    typedef struct {
        int          due;
        logic [18:0] addr;
    } rd_t;

    rd_t         inflight[$];
    int          n = 0;
    logic [18:0] expAddr;
    logic [23:0] expDispRgb;
    logic        expDispValid;
    logic        expBusy;
    logic        expAck;
    logic [23:0] expQRgb;
    logic        expQErr;
    bit          qActive = 0;
    bit          qOob;
    bit          qIssued;
    int          qAcc;
    int          qDone;
    int          qx;
    int          qy;

    // Reference: display reads return 2 edges after issue; a query issues on the first
    // free edge at least 2 edges after accept and finishes 2 edges later
    task automatic modelEdge();
        bit  disp;
        bit  released;
        int  a;
        rd_t r;
        n++;
        if (rst) begin
            inflight.delete();
            qActive      = 0;
            expAddr      = '0;
            expDispRgb   = '0;
            expDispValid = 0;
            expBusy      = 0;
            expAck       = 0;
            expQRgb      = '0;
            expQErr      = 0;
            return;
        end
        disp         = bus.pix_en && bus.active;
        expDispValid = 0;
        while (inflight.size() > 0 && inflight[0].due == n) begin
            r            = inflight.pop_front();
            expDispRgb   = ramColor(r.addr);
            expDispValid = 1;
        end
        released = 0;
        if (qActive && n == qDone + 1) begin
            qActive  = 0;
            released = 1;
        end
        if (disp) begin
            a       = int'(bus.DrawY) * 640 + int'(bus.DrawX);
            expAddr = 19'(a);
            r.due   = n + 2;
            r.addr  = 19'(a);
            inflight.push_back(r);
        end
        if (qActive && !qOob && !qIssued && n >= qAcc + 2 && !disp) begin
            qIssued = 1;
            qDone   = n + 2;
            expAddr = 19'(qy * 640 + qx);
        end
        if (qActive && n == qDone) begin
            expQErr = qOob;
            expQRgb = qOob ? 24'd0 : ramColor(19'(qy * 640 + qx));
        end
        if (!qActive && !released && bus.q_req) begin
            qActive = 1;
            qAcc    = n;
            qx      = int'(bus.q_x);
            qy      = int'(bus.q_y);
            qOob    = (qx >= 640) || (qy >= 480);
            qIssued = 0;
            qDone   = qOob ? n + 1 : -10;
        end
        expBusy = qActive;
        expAck  = qActive && (n == qDone);
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("ram_addr",   24'(bus.ram_addr),   24'(expAddr));
        chk("disp_valid", 24'(bus.disp_valid), 24'(expDispValid));
        chk("disp_rgb",   bus.disp_rgb,        expDispRgb);
        chk("q_busy",     24'(bus.q_busy),     24'(expBusy));
        chk("q_ack",      24'(bus.q_ack),      24'(expAck));
        chk("q_rgb",      bus.q_rgb,           expQRgb);
        chk("q_err",      24'(bus.q_err),      24'(expQErr));
    endtask

    task automatic applyStimulus(input bit r, input bit pe, input bit act, input int dx,
                                 input int dy, input bit req, input int x, input int y);
        rst        = r;
        bus.pix_en = pe;
        bus.active = act;
        bus.DrawX  = 10'(dx);
        bus.DrawY  = 10'(dy);
        bus.q_req  = req;
        bus.q_x    = 10'(x);
        bus.q_y    = 10'(y);
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        bit pe;
        bit act;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Display read of pixel (5,2) with pix_en toggling
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, (i % 2) == 0, 1, 5, 2, 0, 0, 0);
            step();
        end

        // Last in-range pixel queried during blanking
        applyStimulus(0, 0, 0, 0, 0, 1, 639, 479);
        step();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, i % 2, 0, 0, 0, 0, 0, 0);
            step();
        end

        // Out-of-range queries
        applyStimulus(0, 0, 0, 0, 0, 1, 640, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 480);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // q_req held high: busy-time and DONE-cycle requests must be ignored
        applyStimulus(0, 0, 0, 0, 0, 1, 17, 33);
        repeat (14) step();

        // Query interleaved with live video, pix_en alternating
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, (i % 2) == 1, 1, 40 + i, 10, i == 0, 100, 200);
            step();
        end

        // pix_en stuck high: query parks until blanking
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 1, i, 20, i == 0, 3, 4);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Reset while the query sits in WAIT1 with a display read behind it
        applyStimulus(0, 1, 1, 7, 7, 1, 20, 30);
        step();
        applyStimulus(0, 1, 1, 8, 7, 0, 0, 0);
        repeat (2) step();
        applyStimulus(0, 0, 1, 9, 7, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step();

        // Random traffic
        pe  = 0;
        act = 1;
        for (int i = 0; i < 600; i++) begin
            pe = ($urandom_range(0, 3) == 0) ? 1'b1 : !pe;
            if ($urandom_range(0, 29) == 0) act = !act;
            applyStimulus($urandom_range(0, 149) == 0, pe, act,
                          int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                          $urandom_range(0, 5) == 0,
                          int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
